// File: rtl/board_io_pkg.sv
// Shared constants and the colour-expansion helper for the board I/O bridge.
package board_io_pkg;

  // Colour expansion modes.
  localparam int EXPAND_REPLICATE = 0;
  localparam int EXPAND_STEP      = 1;

  // Widest colour channel the helper handles, and the index width for it.
  localparam int MAX_BPC = 16;
  localparam int IDX_W   = 4;

  // Expand an in_bpc-bit colour value (right-aligned in v) to out_bpc bits.
  // The result is right-aligned; callers size-cast it to their DAC width.
  function automatic logic [MAX_BPC-1:0] expand_chan(
    input logic [MAX_BPC-1:0] v,
    input int                 in_bpc,
    input int                 out_bpc,
    input int                 mode
  );
    logic [MAX_BPC-1:0] in_mask;
    logic [MAX_BPC-1:0] out_mask;
    logic [MAX_BPC-1:0] v_m;
    logic [MAX_BPC-1:0] rep;
    logic [MAX_BPC-1:0] res;
    logic [IDX_W-1:0]   dst_idx;
    logic [IDX_W-1:0]   src_idx;
    in_mask  = {MAX_BPC{1'b1}} >> (MAX_BPC - in_bpc);
    out_mask = {MAX_BPC{1'b1}} >> (MAX_BPC - out_bpc);
    v_m      = v & in_mask;
    rep      = {MAX_BPC{1'b0}};
    // Replication: output bit counted from the MSB takes input bit
    // (position mod in_bpc) counted from the MSB.
    for (int j = 0; j < MAX_BPC; j++) begin
      dst_idx = IDX_W'(j);
      if (j < out_bpc) begin
        src_idx      = IDX_W'(in_bpc - 1 - ((out_bpc - 1 - j) % in_bpc));
        rep[dst_idx] = v_m[src_idx];
      end else begin
        src_idx      = {IDX_W{1'b0}};
        rep[dst_idx] = 1'b0;
      end
    end
    if (mode == EXPAND_STEP) begin
      // Full-scale input must reach full-scale output, otherwise plain shift.
      if (v_m == in_mask) begin
        res = out_mask;
      end else begin
        res = v_m << (out_bpc - in_bpc);
      end
    end else begin
      res = rep;
    end
    return res;
  endfunction

endpackage

// File: rtl/board_io_bridge_btn_debounce.sv
// One push-button: 2-flop synchroniser, stability counter, debounced level
// and a registered one-cycle pulse on each qualified press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             press_q, press_d;

  // Next-state: synchronise, count stable cycles, qualify level, detect rise.
  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_dly_d = level_q;
    // Pulse is one cycle after level rose: current level high, previous low.
    press_d     = level_q & ~level_dly_q;
    if (sync2_q == level_q) begin
      cnt_d   = {CNT_W{1'b0}};
      level_d = level_q;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = {CNT_W{1'b0}};
      level_d = sync2_q;
    end else begin
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      level_d = level_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;

endmodule

// File: rtl/board_io_bridge.sv
// Board-side bridge: debounced buttons in, registered and DAC-expanded VGA out.
module board_io_bridge
  import board_io_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int IN_BPC          = 2,
  parameter int OUT_BPC         = 4,
  parameter int EXPAND_MODE     = 1,
  parameter int SYNC_INV        = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   btn_level,
  output logic [N_BTN-1:0]   btn_press,
  input  logic [IN_BPC-1:0]  pix_r,
  input  logic [IN_BPC-1:0]  pix_g,
  input  logic [IN_BPC-1:0]  pix_b,
  input  logic               pix_hs,
  input  logic               pix_vs,
  output logic [OUT_BPC-1:0] vga_r,
  output logic [OUT_BPC-1:0] vga_g,
  output logic [OUT_BPC-1:0] vga_b,
  output logic               vga_hs,
  output logic               vga_vs
);

  localparam logic SYNC_FLIP = (SYNC_INV != 0);

  // Each button has its own independent synchroniser and counter.
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_raw[i]),
      .btn_level(btn_level[i]),
      .btn_press(btn_press[i])
    );
  end

  logic [OUT_BPC-1:0] vga_r_q, vga_r_d;
  logic [OUT_BPC-1:0] vga_g_q, vga_g_d;
  logic [OUT_BPC-1:0] vga_b_q, vga_b_d;
  logic               vga_hs_q, vga_hs_d;
  logic               vga_vs_q, vga_vs_d;

  // Expand colour and apply sync polarity ahead of the single output stage.
  always_comb begin
    vga_r_d  = OUT_BPC'(expand_chan(MAX_BPC'(pix_r), IN_BPC, OUT_BPC, EXPAND_MODE));
    vga_g_d  = OUT_BPC'(expand_chan(MAX_BPC'(pix_g), IN_BPC, OUT_BPC, EXPAND_MODE));
    vga_b_d  = OUT_BPC'(expand_chan(MAX_BPC'(pix_b), IN_BPC, OUT_BPC, EXPAND_MODE));
    vga_hs_d = pix_hs ^ SYNC_FLIP;
    vga_vs_d = pix_vs ^ SYNC_FLIP;
  end

  // Colour and sync share one register stage so they stay aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_r_q  <= {OUT_BPC{1'b0}};
      vga_g_q  <= {OUT_BPC{1'b0}};
      vga_b_q  <= {OUT_BPC{1'b0}};
      vga_hs_q <= 1'b0;
      vga_vs_q <= 1'b0;
    end else begin
      vga_r_q  <= vga_r_d;
      vga_g_q  <= vga_g_d;
      vga_b_q  <= vga_b_d;
      vga_hs_q <= vga_hs_d;
      vga_vs_q <= vga_vs_d;
    end
  end

  assign vga_r  = vga_r_q;
  assign vga_g  = vga_g_q;
  assign vga_b  = vga_b_q;
  assign vga_hs = vga_hs_q;
  assign vga_vs = vga_vs_q;

endmodule

// File: tb/tb_board_io_bridge.sv
// Scoreboard bench for board_io_bridge: three configurations share one clock.
//   u_a: D=8, 2->4 stepped, inverted sync   u_b: D=4, 2->4 replicate
//   u_c: D=4, 3->8 replicate
module tb_board_io_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] btn_a, btn_b, btn_c;
  logic [3:0] lvl_a, prs_a, lvl_b, prs_b, lvl_c, prs_c;
  logic [1:0] p2_r, p2_g, p2_b;
  logic [2:0] p3_r, p3_g, p3_b;
  logic       p_hs, p_vs;
  logic [3:0] ar, ag, ab, br, bg, bb;
  logic [7:0] cr, cg, cb;
  logic       ahs, avs, bhs, bvs, chs, cvs;

  board_io_bridge #(.N_BTN(4), .DEBOUNCE_CYCLES(8), .IN_BPC(2), .OUT_BPC(4),
                    .EXPAND_MODE(1), .SYNC_INV(1)) u_a (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_a), .btn_level(lvl_a), .btn_press(prs_a),
    .pix_r(p2_r), .pix_g(p2_g), .pix_b(p2_b), .pix_hs(p_hs), .pix_vs(p_vs),
    .vga_r(ar), .vga_g(ag), .vga_b(ab), .vga_hs(ahs), .vga_vs(avs));

  board_io_bridge #(.N_BTN(4), .DEBOUNCE_CYCLES(4), .IN_BPC(2), .OUT_BPC(4),
                    .EXPAND_MODE(0), .SYNC_INV(0)) u_b (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_b), .btn_level(lvl_b), .btn_press(prs_b),
    .pix_r(p2_r), .pix_g(p2_g), .pix_b(p2_b), .pix_hs(p_hs), .pix_vs(p_vs),
    .vga_r(br), .vga_g(bg), .vga_b(bb), .vga_hs(bhs), .vga_vs(bvs));

  board_io_bridge #(.N_BTN(4), .DEBOUNCE_CYCLES(4), .IN_BPC(3), .OUT_BPC(8),
                    .EXPAND_MODE(0), .SYNC_INV(0)) u_c (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_c), .btn_level(lvl_c), .btn_press(prs_c),
    .pix_r(p3_r), .pix_g(p3_g), .pix_b(p3_b), .pix_hs(p_hs), .pix_vs(p_vs),
    .vga_r(cr), .vga_g(cg), .vga_b(cb), .vga_hs(chs), .vga_vs(cvs));

  typedef struct { int cyc; logic [3:0] lvl; logic [3:0] prs; } btn_ev_t;
  typedef struct { int cyc; logic [13:0] a; logic [13:0] b; logic [25:0] c; } vid_ev_t;

  btn_ev_t q_a[$];
  btn_ev_t q_b[$];
  vid_ev_t q_v[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  logic [3:0] prev_a = 4'b0;
  logic [3:0] prev_b = 4'b0;

  // Hand-computed video vectors and expected outputs.
  logic [1:0] t_r2[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] t_g2[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic [1:0] t_b2[4] = '{2'b10, 2'b11, 2'b00, 2'b01};
  logic       t_hs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       t_vs[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [2:0] t_r3[4] = '{3'b101, 3'b111, 3'b011, 3'b000};
  logic [2:0] t_g3[4] = '{3'b111, 3'b010, 3'b101, 3'b100};
  logic [2:0] t_b3[4] = '{3'b000, 3'b100, 3'b111, 3'b010};
  // u_a: stepped 00->0000 01->0100 10->1000 11->1111, sync inverted
  logic [13:0] t_ea[4] = '{{4'b0000, 4'b0100, 4'b1000, 1'b0, 1'b1},
                           {4'b0100, 4'b1000, 4'b1111, 1'b1, 1'b0},
                           {4'b1000, 4'b1111, 4'b0000, 1'b0, 1'b0},
                           {4'b1111, 4'b0000, 4'b0100, 1'b1, 1'b1}};
  // u_b: replicate 01->0101 10->1010 11->1111
  logic [13:0] t_eb[4] = '{{4'b0000, 4'b0101, 4'b1010, 1'b1, 1'b0},
                           {4'b0101, 4'b1010, 4'b1111, 1'b0, 1'b1},
                           {4'b1010, 4'b1111, 4'b0000, 1'b1, 1'b1},
                           {4'b1111, 4'b0000, 4'b0101, 1'b0, 1'b0}};
  // u_c: 101->b6 111->ff 011->6d 010->49 100->92
  logic [25:0] t_ec[4] = '{{8'hb6, 8'hff, 8'h00, 1'b1, 1'b0},
                           {8'hff, 8'h49, 8'h92, 1'b0, 1'b1},
                           {8'h6d, 8'hb6, 8'hff, 1'b1, 1'b1},
                           {8'h00, 8'h92, 8'h49, 1'b0, 1'b0}};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Button monitor for u_a: any level change or press pulse is an event.
  always @(negedge clk) begin
    if (mon_en && (lvl_a !== prev_a || prs_a !== 4'b0)) begin
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_event actual=lvl %b prs %b required=no event (cycle %0d)",
                 lvl_a, prs_a, cyc);
      end else begin
        btn_ev_t e;
        e = q_a.pop_front();
        chk("a_event_cycle", cyc, e.cyc);
        chk("a_level", {28'b0, lvl_a}, {28'b0, e.lvl});
        chk("a_press", {28'b0, prs_a}, {28'b0, e.prs});
      end
    end
    prev_a = lvl_a;
  end

  // Button monitor for u_b.
  always @(negedge clk) begin
    if (mon_en && (lvl_b !== prev_b || prs_b !== 4'b0)) begin
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_event actual=lvl %b prs %b required=no event (cycle %0d)",
                 lvl_b, prs_b, cyc);
      end else begin
        btn_ev_t e;
        e = q_b.pop_front();
        chk("b_event_cycle", cyc, e.cyc);
        chk("b_level", {28'b0, lvl_b}, {28'b0, e.lvl});
        chk("b_press", {28'b0, prs_b}, {28'b0, e.prs});
      end
    end
    prev_b = lvl_b;
  end

  // Video monitor: compare all three DUTs in the cycle each entry is due.
  always @(negedge clk) begin
    if (mon_en) begin
      while (q_v.size() > 0 && q_v[0].cyc < cyc) begin
        vid_ev_t s;
        s = q_v.pop_front();
        total++;
        bad++;
        $display("FAIL vid_missed actual=none required=entry for cycle %0d", s.cyc);
      end
      if (q_v.size() > 0 && q_v[0].cyc == cyc) begin
        vid_ev_t e;
        e = q_v.pop_front();
        chk("vid_a", {18'b0, ar, ag, ab, ahs, avs}, {18'b0, e.a});
        chk("vid_b", {18'b0, br, bg, bb, bhs, bvs}, {18'b0, e.b});
        chk("vid_c", {6'b0, cr, cg, cb, chs, cvs}, {6'b0, e.c});
      end
    end
  end

  task automatic push_a(input int c, input logic [3:0] l, input logic [3:0] p);
    btn_ev_t e;
    e.cyc = c; e.lvl = l; e.prs = p;
    q_a.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    btn_a = 4'hf; btn_b = 4'hf; btn_c = 4'h0;
    p2_r = 2'b11; p2_g = 2'b11; p2_b = 2'b11;
    p3_r = 3'b111; p3_g = 3'b111; p3_b = 3'b111;
    p_hs = 1'b1; p_vs = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    // Reset state with every input high.
    chk("rst_lvl_a", {28'b0, lvl_a}, 32'd0);
    chk("rst_prs_a", {28'b0, prs_a}, 32'd0);
    chk("rst_lvl_b", {28'b0, lvl_b}, 32'd0);
    chk("rst_prs_b", {28'b0, prs_b}, 32'd0);
    chk("rst_btn_c", {24'b0, lvl_c, prs_c}, 32'd0);
    chk("rst_vid_a", {18'b0, ar, ag, ab, ahs, avs}, 32'd0);
    chk("rst_vid_b", {18'b0, br, bg, bb, bhs, bvs}, 32'd0);
    chk("rst_vid_c", {6'b0, cr, cg, cb, chs, cvs}, 32'd0);

    // Release reset with u_b button 0 held: first sample at c0+1,
    // level at c0+1+4+1, press one cycle later.
    next_cycle();
    btn_a = 4'h0;
    btn_b = 4'b0001;
    rst_n = 1'b1;
    mon_en = 1'b1;
    c0 = cyc;
    q_b.push_back('{cyc: c0 + 6, lvl: 4'b0001, prs: 4'b0000});
    q_b.push_back('{cyc: c0 + 7, lvl: 4'b0001, prs: 4'b0001});
    repeat (15) next_cycle();

    // Glitch of 7 cycles on u_a button 1 (D=8): must be rejected.
    btn_a = 4'b0010;
    repeat (7) next_cycle();
    btn_a = 4'b0000;
    repeat (15) next_cycle();

    // Hold button 1 for 20 cycles: level at E+9, press at E+10.
    btn_a = 4'b0010;
    c0 = cyc;
    push_a(c0 + 10, 4'b0010, 4'b0000);
    push_a(c0 + 11, 4'b0010, 4'b0010);
    repeat (20) next_cycle();
    // Release: level falls after the window, no pulse.
    btn_a = 4'b0000;
    c0 = cyc;
    push_a(c0 + 10, 4'b0000, 4'b0000);
    repeat (15) next_cycle();

    // Two buttons toggled together qualify in the same cycle.
    btn_a = 4'b1100;
    c0 = cyc;
    push_a(c0 + 10, 4'b1100, 4'b0000);
    push_a(c0 + 11, 4'b1100, 4'b1100);
    repeat (20) next_cycle();
    btn_a = 4'b0000;
    c0 = cyc;
    push_a(c0 + 10, 4'b0000, 4'b0000);
    repeat (15) next_cycle();

    // Video sweep: each vector registered one cycle after it is driven.
    for (int i = 0; i < 4; i++) begin
      vid_ev_t e;
      next_cycle();
      p2_r = t_r2[i]; p2_g = t_g2[i]; p2_b = t_b2[i];
      p3_r = t_r3[i]; p3_g = t_g3[i]; p3_b = t_b3[i];
      p_hs = t_hs[i]; p_vs = t_vs[i];
      e.cyc = cyc + 1; e.a = t_ea[i]; e.b = t_eb[i]; e.c = t_ec[i];
      q_v.push_back(e);
    end
    repeat (6) next_cycle();
    @(negedge clk);
    #1;

    chk("a_queue_drained", q_a.size(), 32'd0);
    chk("b_queue_drained", q_b.size(), 32'd0);
    chk("vid_queue_drained", q_v.size(), 32'd0);
    chk("c_btn_idle", {24'b0, lvl_c, prs_c}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_io_bridge.md
# board_io_bridge

Parametrised board-side I/O bridge between a TinyTapeout-style user design and an FPGA board. It synchronises and debounces N raw push-buttons, producing clean levels and one-cycle press pulses. It also registers the design's low-depth VGA colour and sync signals and expands each colour channel to the board DAC width using a selectable expansion mode. It sits in the board top level, between the pins and the user project.

## Interface
- `N_BTN`, 4: number of button inputs.
- `DEBOUNCE_CYCLES`, 250000: number of stable cycles required before a level change is accepted (10 ms at 25 MHz); must be ≥ 1.
- `IN_BPC`, 2: design colour bits per channel.
- `OUT_BPC`, 4: board DAC bits per channel; must be ≥ `IN_BPC`.
- `EXPAND_MODE`, 1: 0 = bit replication, 1 = stepped shift with saturate-at-max.
- `SYNC_INV`, 0: 1 inverts hsync/vsync before the output register.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `btn_raw` in N_BTN: asynchronous button pins, active high.
- `btn_level` out N_BTN: debounced level.
- `btn_press` out N_BTN: one-cycle pulse on each debounced 0→1 transition.
- `pix_r`, `pix_g`, `pix_b` in IN_BPC each: colour channels from the design.
- `pix_hs`, `pix_vs` in 1 each: sync signals from the design.
- `vga_r`, `vga_g`, `vga_b` out OUT_BPC each: expanded, registered colour channels.
- `vga_hs`, `vga_vs` out 1 each: registered sync signals.

## Operation
- Per button:
  - 2-flop synchroniser feeds `s2`.
  - Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)` (minimum 1), and register `level`.
  - `s2 == level`: `cnt` is cleared.
  - `s2 != level` and `cnt == DEBOUNCE_CYCLES-1`: `level` takes `s2`, `cnt` is cleared.
  - Otherwise: `cnt` increments.
  - A glitch shorter than the debounce window restarts the count and never changes `level`.
  - `btn_press` is registered. It is 1 exactly in the cycle after the edge where `level` went 0→1. A 1→0 transition produces no pulse.
- Colour expansion, per channel value `v` of IN_BPC bits:
  - Mode 0: `v` replicated MSB-first and truncated to OUT_BPC (for 2→4, 01→0101, 10→1010).
  - Mode 1: if `v` is all ones, output is all ones; else output is `v << (OUT_BPC-IN_BPC)` (for 2→4: 00→0000, 01→0100, 10→1000, 11→1111).
  - IN_BPC == OUT_BPC: both modes pass `v` through unchanged.
- Sync signals: `vga_hs = pix_hs ^ SYNC_INV` and `vga_vs = pix_vs ^ SYNC_INV`, registered.

## Timing
- Reset values, held while `rst_n` is 0 at a rising edge:
  - Synchronisers, `cnt`, `btn_level`, `btn_press` = 0.
  - `vga_r`, `vga_g`, `vga_b` = 0.
  - `vga_hs`, `vga_vs` = 0, regardless of `SYNC_INV`.
- Button latency:
  - A raw change held stable is first sampled at edge E.
  - `btn_level` changes at edge E+DEBOUNCE_CYCLES+1.
  - `btn_press` is high from edge E+DEBOUNCE_CYCLES+2 for one cycle.
- Video latency: exactly 1 cycle. Colour and sync are registered in the same stage, so the skew between them is 0.
- Reset mid-debounce discards the partial count. A button held through reset release must be re-qualified over a full window and then produces one press pulse.
- Buttons are fully independent. Simultaneous transitions on several buttons qualify in parallel, each on its own counter.

## Structure
- Package `board_io_pkg` contains:
  - Constants `EXPAND_REPLICATE = 0` and `EXPAND_STEP = 1`.
  - Function `expand_chan(v, mode)`, parametrised through package parameters or width arguments.
- Sub-module `btn_debounce` contains one synchroniser, counter and level/press logic, with `DEBOUNCE_CYCLES` as a parameter. It is instantiated N_BTN times with a generate loop.
- Video expansion is inline in the top module: three `expand_chan` calls feeding one register stage.

## Test plan
- **Reset:** `rst_n` = 0 with all inputs at 1 → every output is 0. Release reset with `btn_raw[0]` held at 1 and DEBOUNCE_CYCLES = 4 → `btn_level[0]` rises 5 edges after release, followed by a single press pulse.
- **Glitch rejection:** DEBOUNCE_CYCLES = 8; pulse `btn_raw[1]` high for 7 cycles → `btn_level[1]` stays 0 and no press pulse. Then hold it high for 20 cycles → level rises at E+9 and a press pulse at E+10, 1 cycle wide.
- **Release:** hold a button, let it qualify, then release → `btn_level` falls after the window and no pulse is generated. Two buttons toggled in the same cycle → both qualify in the same cycle.
- **Expansion mode 1 (2→4):** sweep `pix_r` through 0–3 → `vga_r` one cycle later is 0000, 0100, 1000, 1111.
- **Expansion mode 0 (2→4 and 3→8):** for 2→4, input 10 → 1010. For 3→8, input 101 → 10110110, and 111 → 11111111.
- **Video timing:** toggle `pix_hs`/`pix_vs` with SYNC_INV = 1 → outputs are inverted, delayed 1 cycle, and aligned with the colour channels.
